debounce_gpi_core: RTL and testbench



---
 rtl/debounce_gpi_core.sv | 106 ++++++++++
 tb/tb_debounce_gpi_core.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_gpi_core.sv
// Debounced general-purpose input slot for the MMIO subsystem.
// Each input is synchronized and debounced, and its edges are latched in sticky W1C bits that can raise an irq.
module debounce_gpi_core #(
  parameter int W             = 8,
  parameter int CNT_W         = 20,
  parameter int DEFAULT_TICKS = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  output logic [31:0]  rd_data,
  input  logic [31:0]  wr_data,
  input  logic [W-1:0] din,
  output logic         irq
);

  logic [W-1:0]     r_s1;
  logic [W-1:0]     r_s2;
  logic [W-1:0]     r_db;
  logic [W-1:0]     r_edge;
  logic [W-1:0]     r_mode;
  logic [W-1:0]     r_ie;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt [W];

  logic [CNT_W-1:0] w_lim;
  logic [W-1:0]     w_db_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [W];
  logic [W-1:0]     w_rise;
  logic [W-1:0]     w_fall;
  logic [W-1:0]     w_set;
  logic [W-1:0]     w_clr;
  logic             w_we;
  logic             w_unused;

  assign w_unused = ^{read, wr_data};
  assign w_we     = cs & write;

  // A period of 0 behaves like a period of 1.
  assign w_lim = (r_period == '0) ? '0 : r_period - 1'b1;

  always_comb begin
    w_db_nxt = r_db;
    for (int i = 0; i < W; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_db[i]) begin
        if (r_cnt[i] >= w_lim)
          w_db_nxt[i] = r_s2[i];
        else
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  assign w_rise = w_db_nxt & ~r_db;
  assign w_fall = ~w_db_nxt & r_db;
  assign w_set  = (w_rise & ~r_mode) | (w_fall & r_mode);
  assign w_clr  = (w_we && addr == 5'd2) ? wr_data[W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_db     <= '0;
      r_edge   <= '0;
      r_mode   <= '0;
      r_ie     <= '0;
      r_period <= CNT_W'(DEFAULT_TICKS);
      for (int i = 0; i < W; i++)
        r_cnt[i] <= '0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
      r_db <= w_db_nxt;
      for (int i = 0; i < W; i++)
        r_cnt[i] <= w_cnt_nxt[i];
      // A new edge wins over a same-cycle clear.
      r_edge <= (r_edge & ~w_clr) | w_set;
      if (w_we && addr == 5'd3)
        r_period <= wr_data[CNT_W-1:0];
      if (w_we && addr == 5'd4)
        r_mode <= wr_data[W-1:0];
      if (w_we && addr == 5'd5)
        r_ie <= wr_data[W-1:0];
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0:    rd_data = 32'(r_db);
      5'd1:    rd_data = 32'(r_s2);
      5'd2:    rd_data = 32'(r_edge);
      5'd3:    rd_data = 32'(r_period);
      5'd4:    rd_data = 32'(r_mode);
      5'd5:    rd_data = 32'(r_ie);
      default: rd_data = '0;
    endcase
  end

  assign irq = |(r_edge & r_ie);

endmodule

// File: tb/tb_debounce_gpi_core.sv
// Bench for debounce_gpi_core: reset table, debounce timing,
// bounce, W1C/irq, falling mode, period and reset corners.
module tb_debounce_gpi_core;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         cs;
  logic         read;
  logic         write;
  logic [4:0]   addr;
  logic [31:0]  rd_data;
  logic [31:0]  wr_data;
  logic [W-1:0] din;
  logic         irq;

  int n_cmp;
  int n_bad;
  logic [31:0] sb[$];

  typedef struct {
    logic [4:0]  a;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[8];

  debounce_gpi_core #(
    .W(W),
    .CNT_W(20),
    .DEFAULT_TICKS(1000000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .read(read),
    .write(write),
    .addr(addr),
    .rd_data(rd_data),
    .wr_data(wr_data),
    .din(din),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1;
    write = 1'b1;
    addr = a;
    wr_data = d;
    tick();
    cs = 1'b0;
    write = 1'b0;
    wr_data = '0;
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp,
                        input string nm);
    cs = 1'b1;
    read = 1'b1;
    addr = a;
    sb.push_back(exp);
    #1;
    cmp(nm, rd_data, sb.pop_front());
    cs = 1'b0;
    read = 1'b0;
  endtask

  task automatic irq_chk(input logic exp, input string nm);
    cmp(nm, {31'b0, irq}, {31'b0, exp});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    cs = 1'b0;
    read = 1'b0;
    write = 1'b0;
    addr = '0;
    wr_data = '0;
    din = '0;

    tbl[0] = '{5'd0,  32'h0,        "rst_db"};
    tbl[1] = '{5'd1,  32'h0,        "rst_s2"};
    tbl[2] = '{5'd2,  32'h0,        "rst_edge"};
    tbl[3] = '{5'd3,  32'h000F4240, "rst_period"};
    tbl[4] = '{5'd4,  32'h0,        "rst_mode"};
    tbl[5] = '{5'd5,  32'h0,        "rst_ie"};
    tbl[6] = '{5'd6,  32'h0,        "rst_a6"};
    tbl[7] = '{5'd31, 32'h0,        "rst_a31"};

    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++)
      rd_chk(tbl[i].a, tbl[i].exp, tbl[i].nm);
    irq_chk(1'b0, "rst_irq");

    // Clean rise, period 4: db follows 6 cycles later.
    wr(5'd3, 32'd4);
    rd_chk(5'd3, 32'd4, "period_rb");
    wr(5'd0, 32'hFF);
    wr(5'd1, 32'hFF);
    rd_chk(5'd0, 32'h0, "ro_a0");
    din = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd_chk(5'd0, (k == 6) ? 32'h1 : 32'h0, "clean_db");
    end
    rd_chk(5'd2, 32'h1, "clean_edge");

    // Return to 0 and clear edges.
    din = 8'h00;
    for (int k = 0; k < 8; k++) tick();
    rd_chk(5'd0, 32'h0, "fall_db");
    rd_chk(5'd2, 32'h1, "edge_sticky");
    wr(5'd2, 32'hFF);
    rd_chk(5'd2, 32'h0, "w1c_all");

    // Bounce: 3 high, 1 low, then held high.
    din = 8'h01;
    for (int k = 0; k < 3; k++) begin
      tick();
      rd_chk(5'd0, 32'h0, "bnc_hi");
    end
    din = 8'h00;
    tick();
    rd_chk(5'd0, 32'h0, "bnc_lo");
    din = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd_chk(5'd0, (k == 6) ? 32'h1 : 32'h0, "bnc_db");
    end
    rd_chk(5'd2, 32'h1, "bnc_edge");

    // W1C and irq.
    irq_chk(1'b0, "irq_no_ie");
    wr(5'd5, 32'h1);
    rd_chk(5'd5, 32'h1, "ie_rb");
    irq_chk(1'b1, "irq_on");
    wr(5'd2, 32'h1);
    rd_chk(5'd2, 32'h0, "w1c_bit0");
    irq_chk(1'b0, "irq_off");

    // New rising edge landing on the W1C cycle.
    din = 8'h00;
    for (int k = 0; k < 8; k++) tick();
    rd_chk(5'd0, 32'h0, "race_pre");
    din = 8'h01;
    for (int k = 0; k < 5; k++) tick();
    rd_chk(5'd2, 32'h0, "race_before");
    wr(5'd2, 32'h1);
    rd_chk(5'd0, 32'h1, "race_db");
    rd_chk(5'd2, 32'h1, "race_set_wins");
    irq_chk(1'b1, "race_irq");
    wr(5'd2, 32'h1);

    // Falling mode on bit1.
    wr(5'd4, 32'h2);
    rd_chk(5'd4, 32'h2, "mode_rb");
    din = 8'h03;
    for (int k = 1; k <= 10; k++) begin
      tick();
      rd_chk(5'd2, 32'h0, "fm_rise");
    end
    rd_chk(5'd0, 32'h3, "fm_db_hi");
    din = 8'h01;
    for (int k = 1; k <= 10; k++) begin
      tick();
      rd_chk(5'd2, (k >= 6) ? 32'h2 : 32'h0, "fm_fall");
    end
    irq_chk(1'b0, "fm_irq_masked");

    // Period 0 behaves as 1.
    wr(5'd3, 32'd0);
    rd_chk(5'd3, 32'd0, "p0_rb");
    din = 8'h00;
    for (int k = 1; k <= 3; k++) begin
      tick();
      rd_chk(5'd0, (k == 3) ? 32'h0 : 32'h1, "p0_db");
    end

    // Reset mid-count (cnt=2 of 4).
    wr(5'd3, 32'd4);
    din = 8'h01;
    for (int k = 0; k < 4; k++) tick();
    rd_chk(5'd0, 32'h0, "mid_db");
    reset = 1'b1;
    tick();
    tick();
    rd_chk(5'd0, 32'h0, "mr_db");
    rd_chk(5'd2, 32'h0, "mr_edge");
    rd_chk(5'd3, 32'h000F4240, "mr_period");
    rd_chk(5'd4, 32'h0, "mr_mode");
    reset = 1'b0;
    wr(5'd3, 32'd4);
    for (int k = 2; k <= 6; k++) begin
      rd_chk(5'd0, 32'h0, "mr_cnt_clr");
      tick();
    end
    rd_chk(5'd0, 32'h1, "mr_db_after");
    rd_chk(5'd2, 32'h1, "mr_edge_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
